pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard and stall sequencer for the 5-stage pipeline. It drives enable and flush signals for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, redirects on branches and jumps resolved in the MEM stage, and freezes the pipeline while a data-memory access waits for acknowledge. It also provides forwarding selects for the EX stage and a saturating stall-cycle counter for performance debug.

Parameters:
MEM_TIMEOUT, 15, max cycles MEM_WAIT waits for dmem_ack before flagging mem_err (1..255)
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  clock, rising edge
clr  in  1  reset, asynchronous, active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
ex_rs  in  5  rs of instruction in EX
ex_rt  in  5  rt of instruction in EX
ex_regwrite  in  1  EX instruction writes a register
ex_memtoreg  in  1  EX instruction is a load
ex_writereg  in  5  EX destination register
mem_regwrite  in  1  MEM instruction writes a register
mem_writereg  in  5  MEM destination register
mem_memtoreg  in  1  MEM instruction is a load
mem_memwrite  in  1  MEM instruction is a store
mem_branch_eq  in  1  MEM instruction is beq
mem_zero  in  1  ALU zero flag latched in EX/MEM
mem_jump  in  1  MEM instruction is a jump
wb_regwrite  in  1  WB instruction writes a register
wb_writereg  in  5  WB destination register
dmem_ack  in  1  data memory completes the current access
pc_en  out  1  PC update enable
pc_sel  out  2  0 = pc+4, 1 = branch target, 2 = jump target
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear
idex_en  out  1  ID/EX load enable
idex_flush  out  1  ID/EX clear (bubble)
exmem_en  out  1  EX/MEM load enable
exmem_flush  out  1  EX/MEM clear (drives flushCtrl)
memwb_flush  out  1  MEM/WB clear
dmem_req  out  1  data memory request
fwd_a  out  2  EX operand A select: 0 = regfile, 1 = MEM alu_out, 2 = WB result
fwd_b  out  2  EX operand B select, same encoding as fwd_a
mem_err  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  saturating count of cycles with pc_en = 0

Behaviour:
- FSM states: RUN, MEM_WAIT. Reset state is RUN. Wait counter resets to 0.
- Output values during reset: mem_err = 0, stall_cnt = 0. All enables are 1, all flushes are 0, pc_sel = 0, dmem_req = 0, fwd = 0.
- Outputs other than mem_err and stall_cnt are combinational from the current state and inputs. Register effects occur at the next rising edge.
- mem_access = mem_memtoreg | mem_memwrite.
- RUN with mem_access = 1:
  - dmem_req = 1.
  - If dmem_ack = 1 in the same cycle, there is no stall.
  - Otherwise go to MEM_WAIT and freeze the pipeline this cycle: pc_en, ifid_en, idex_en and exmem_en = 0, memwb_flush = 1.
- MEM_WAIT:
  - dmem_req = 1 and the pipeline is frozen as above.
  - On dmem_ack: unfreeze in that cycle (enables = 1, memwb_flush = 0) and go to RUN.
  - Wait counter increments each cycle in MEM_WAIT. When it reaches MEM_TIMEOUT, set mem_err (sticky until clr), go to RUN, and release the freeze.
- Redirect (RUN only, not frozen): taken = (mem_branch_eq & mem_zero) | mem_jump.
  - pc_sel = 2 if mem_jump, else 1.
  - ifid_flush = idex_flush = exmem_flush = 1.
- Load-use (RUN, not frozen, no redirect): ex_memtoreg & ex_regwrite & ex_writereg != 0 & (ex_writereg == id_rs | ex_writereg == id_rt).
  - pc_en = ifid_en = 0 and idex_flush = 1, for exactly one cycle.
- Priority: freeze > redirect > load-use. A redirect or load-use that coincides with a freeze is re-evaluated after the freeze, because the stage contents are held.
- Forwarding for fwd_a (fwd_b is the same with ex_rt):
  - 1 if mem_regwrite & mem_writereg != 0 & mem_writereg == ex_rs.
  - Else 2 if wb_regwrite & wb_writereg != 0 & wb_writereg == ex_rs.
  - Else 0.
  - MEM has priority over WB.
- stall_cnt increments on every edge where pc_en = 0 and saturates at all-ones.
- If clr is asserted mid-wait: return immediately to RUN, drop dmem_req, clear the counters.

Decomposition:
- Shared package pipe_pkg holds the state encoding (RUN, MEM_WAIT), the PC_SEL_* constants and the FWD_* constants.
- One sub-module, fwd_unit (combinational forwarding compare), is instantiated once and feeds fwd_a/fwd_b. Everything else stays in pipe_hazard_ctrl.

Test Plan:
- Load-use: ex_memtoreg = 1, ex_regwrite = 1, ex_writereg = 8, id_rs = 8 -> one cycle with pc_en = 0, ifid_en = 0, idex_flush = 1; next cycle (ex_memtoreg = 0) all enables = 1; stall_cnt = 1.
- Branch taken: mem_branch_eq = 1, mem_zero = 1 -> pc_sel = 1 and ifid/idex/exmem_flush = 1 for one cycle. With mem_zero = 0 -> pc_sel = 0, no flush. With mem_jump = 1 -> pc_sel = 2.
- Memory wait: mem_memtoreg = 1, dmem_ack arrives 3 cycles later -> dmem_req held 4 cycles, exmem_en = 0 and memwb_flush = 1 for 3 cycles, back in RUN, stall_cnt = 3.
- Timeout: mem_memwrite = 1, dmem_ack never asserted, MEM_TIMEOUT = 15 -> mem_err rises after the wait counter reaches 15, FSM returns to RUN, mem_err stays 1 until clr.
- Priority and forwarding:
  - Freeze plus taken branch together -> no flush and pc_sel = 0 during the freeze; the flush happens in the cycle the ack arrives.
  - mem_writereg = wb_writereg = ex_rs = 5 with both regwrites set -> fwd_a = 1.
  - ex_rs = 0 -> fwd_a = 0.
- Async reset: assert clr mid-MEM_WAIT between clock edges -> dmem_req = 0, stall_cnt = 0 and mem_err = 0 immediately, state RUN.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, PC select and forwarding select codes.
package pipe_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] PC_SEL_PC4 = 2'd0;
    localparam logic [1:0] PC_SEL_BR  = 2'd1;
    localparam logic [1:0] PC_SEL_JMP = 2'd2;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Data-memory request/acknowledge handshake.
// master: controller (drives dmem_req); slave: memory (drives dmem_ack).
interface pipe_hazard_ctrl_if;

    logic dmem_req;
    logic dmem_ack;

    modport master (output dmem_req, input dmem_ack);
    modport slave  (input dmem_req, output dmem_ack);

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational EX-stage operand forwarding selects.
// In: EX sources, MEM/WB destinations; out: fwd_a, fwd_b.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic       mem_regwrite,
    input  logic [4:0] mem_writereg,
    input  logic       wb_regwrite,
    input  logic [4:0] wb_writereg,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    function automatic logic [1:0] pick(input logic [4:0] src);
        if (mem_regwrite && mem_writereg != 5'd0 && mem_writereg == src)
            return FWD_MEM;
        else if (wb_regwrite && wb_writereg != 5'd0 && wb_writereg == src)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        fwd_a = pick(ex_rs);
        fwd_b = pick(ex_rt);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer: freeze on dmem wait, redirect, load-use bubble.
// In: pipeline stage fields, dmem_ack; out: enables, flushes, fwd, stats.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             ex_regwrite,
    input  logic             ex_memtoreg,
    input  logic [4:0]       ex_writereg,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_writereg,
    input  logic             mem_memtoreg,
    input  logic             mem_memwrite,
    input  logic             mem_branch_eq,
    input  logic             mem_zero,
    input  logic             mem_jump,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_writereg,
    pipe_hazard_ctrl_if.master dmem,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       mem_access;
    logic       timeout;
    logic       freeze;
    logic       taken;
    logic       load_use;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    fwd_unit u_fwd (
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .mem_regwrite (mem_regwrite),
        .mem_writereg (mem_writereg),
        .wb_regwrite  (wb_regwrite),
        .wb_writereg  (wb_writereg),
        .fwd_a        (fwd_a_raw),
        .fwd_b        (fwd_b_raw)
    );

    always_comb begin
        mem_access    = mem_memtoreg | mem_memwrite;
        timeout       = 1'b0;
        freeze        = 1'b0;
        dmem.dmem_req = 1'b0;
        state_nxt     = state;
        unique case (state)
            RUN: begin
                dmem.dmem_req = mem_access;
                freeze        = mem_access & ~dmem.dmem_ack;
                if (freeze)
                    state_nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                dmem.dmem_req = 1'b1;
                // Last allowed wait cycle: give up and let the access drain.
                timeout = ~dmem.dmem_ack & (wait_cnt == TO_LAST);
                freeze  = ~dmem.dmem_ack & ~timeout;
                if (!freeze)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
        // Outputs hold their idle values while clr is asserted.
        if (clr) begin
            dmem.dmem_req = 1'b0;
            freeze        = 1'b0;
            timeout       = 1'b0;
        end
        // Held stages mean redirect/load-use re-evaluate once unfrozen.
        taken    = ~clr & ~freeze &
                   ((mem_branch_eq & mem_zero) | mem_jump);
        load_use = ~clr & ~freeze & ~taken &
                   ex_memtoreg & ex_regwrite & (ex_writereg != 5'd0) &
                   ((ex_writereg == id_rs) | (ex_writereg == id_rt));

        pc_en       = ~(freeze | load_use);
        ifid_en     = ~(freeze | load_use);
        idex_en     = ~freeze;
        exmem_en    = ~freeze;
        memwb_flush = freeze;
        ifid_flush  = taken;
        idex_flush  = taken | load_use;
        exmem_flush = taken;
        pc_sel      = !taken  ? PC_SEL_PC4 :
                      mem_jump ? PC_SEL_JMP : PC_SEL_BR;
        fwd_a       = clr ? FWD_RF : fwd_a_raw;
        fwd_b       = clr ? FWD_RF : fwd_b_raw;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == MEM_WAIT && state_nxt == MEM_WAIT) ?
                        wait_cnt + 8'd1 : 8'd0;
            mem_err  <= mem_err | timeout;
            if (!pc_en && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized scoreboard bench for pipe_hazard_ctrl.
// Driver pushes expected responses; negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    localparam int TO  = 15;
    localparam int CW  = 5;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic [4:0]    id_rs, id_rt, ex_rs, ex_rt, ex_writereg;
    logic          ex_regwrite, ex_memtoreg;
    logic          mem_regwrite, mem_memtoreg, mem_memwrite;
    logic [4:0]    mem_writereg, wb_writereg;
    logic          mem_branch_eq, mem_zero, mem_jump, wb_regwrite;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic          exmem_en, exmem_flush, memwb_flush, mem_err;
    logic [1:0]    pc_sel, fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt;

    pipe_hazard_ctrl_if dmem ();

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .clr(clr),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
        .ex_writereg(ex_writereg), .mem_regwrite(mem_regwrite),
        .mem_writereg(mem_writereg), .mem_memtoreg(mem_memtoreg),
        .mem_memwrite(mem_memwrite), .mem_branch_eq(mem_branch_eq),
        .mem_zero(mem_zero), .mem_jump(mem_jump),
        .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg),
        .dmem(dmem.master),
        .pc_en(pc_en), .pc_sel(pc_sel), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic       pc_en;
        logic [1:0] pc_sel;
        logic       ifid_en, ifid_flush, idex_en, idex_flush;
        logic       exmem_en, exmem_flush, memwb_flush, dmem_req;
        logic [1:0] fwd_a, fwd_b;
        logic       err;
        int         stalls;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;

    // Reference model: is an access outstanding, how long, error, stalls.
    bit   m_wait;
    int   m_waited;
    bit   m_err;
    int   m_stalls;
    int   acc_pct, ack_pct;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, want,
                     $time);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] src);
        if (mem_regwrite && mem_writereg != 0 && mem_writereg == src)
            return 2'd1;
        if (wb_regwrite && wb_writereg != 0 && wb_writereg == src)
            return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_wait   = 0;
        m_waited = 0;
        m_err    = 0;
        m_stalls = 0;
    endtask

    task automatic drive();
        exp_t e;
        bit acc, ack, frozen, taken, lu;
        id_rs         = 5'($urandom_range(0, 3));
        id_rt         = 5'($urandom_range(0, 3));
        ex_rs         = 5'($urandom_range(0, 5));
        ex_rt         = 5'($urandom_range(0, 5));
        ex_writereg   = 5'($urandom_range(0, 3));
        ex_regwrite   = 1'($urandom_range(0, 1));
        ex_memtoreg   = ($urandom_range(0, 2) == 0);
        mem_regwrite  = 1'($urandom_range(0, 1));
        mem_writereg  = 5'($urandom_range(0, 5));
        wb_regwrite   = 1'($urandom_range(0, 1));
        wb_writereg   = 5'($urandom_range(0, 5));
        mem_branch_eq = ($urandom_range(0, 3) == 0);
        mem_zero      = 1'($urandom_range(0, 1));
        mem_jump      = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 99) < acc_pct) begin
            mem_memtoreg = 1'($urandom_range(0, 1));
            mem_memwrite = ~mem_memtoreg;
        end else begin
            mem_memtoreg = 1'b0;
            mem_memwrite = 1'b0;
        end
        ack = ($urandom_range(0, 99) < ack_pct);
        dmem.dmem_ack = ack;

        acc = mem_memtoreg | mem_memwrite;
        if (m_wait)
            frozen = !ack && (m_waited + 1 < TO);
        else
            frozen = acc && !ack;
        taken = !frozen && ((mem_branch_eq && mem_zero) || mem_jump);
        lu = !frozen && !taken && ex_memtoreg && ex_regwrite &&
             ex_writereg != 0 &&
             (ex_writereg == id_rs || ex_writereg == id_rt);

        e.pc_en       = !(frozen || lu);
        e.pc_sel      = !taken ? 2'd0 : (mem_jump ? 2'd2 : 2'd1);
        e.ifid_en     = e.pc_en;
        e.ifid_flush  = taken;
        e.idex_en     = !frozen;
        e.idex_flush  = taken || lu;
        e.exmem_en    = !frozen;
        e.exmem_flush = taken;
        e.memwb_flush = frozen;
        e.dmem_req    = m_wait || acc;
        e.fwd_a       = fwd_ref(ex_rs);
        e.fwd_b       = fwd_ref(ex_rt);
        e.err         = m_err;
        e.stalls      = m_stalls;
        q.push_back(e);

        if (!e.pc_en && m_stalls < SAT)
            m_stalls++;
        if (m_wait) begin
            if (ack) begin
                m_wait = 0;
            end else if (m_waited + 1 >= TO) begin
                m_err  = 1;
                m_wait = 0;
            end else begin
                m_waited++;
            end
        end else if (acc && !ack) begin
            m_wait   = 1;
            m_waited = 0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive();
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                me = q.pop_front();
                check("pc_en", pc_en, me.pc_en);
                check("pc_sel", pc_sel, me.pc_sel);
                check("ifid_en", ifid_en, me.ifid_en);
                check("ifid_flush", ifid_flush, me.ifid_flush);
                check("idex_en", idex_en, me.idex_en);
                check("idex_flush", idex_flush, me.idex_flush);
                check("exmem_en", exmem_en, me.exmem_en);
                check("exmem_flush", exmem_flush, me.exmem_flush);
                check("memwb_flush", memwb_flush, me.memwb_flush);
                check("dmem_req", dmem.dmem_req, me.dmem_req);
                check("fwd_a", fwd_a, me.fwd_a);
                check("fwd_b", fwd_b, me.fwd_b);
                check("mem_err", mem_err, me.err);
                check("stall_cnt", stall_cnt, me.stalls);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        {id_rs, id_rt, ex_rs, ex_rt, ex_writereg} = '0;
        {ex_regwrite, ex_memtoreg, mem_regwrite, mem_memwrite} = '0;
        {mem_writereg, wb_writereg, wb_regwrite, mem_jump} = '0;
        {mem_branch_eq, mem_zero} = '0;
        mem_memtoreg  = 1'b1;
        ex_memtoreg   = 1'b1;
        ex_regwrite   = 1'b1;
        ex_writereg   = 5'd2;
        id_rs         = 5'd2;
        dmem.dmem_ack = 1'b0;
        acc_pct       = 25;
        ack_pct       = 40;
        model_reset();
        #12;
        check("rst_pc_en", pc_en, 1'b1);
        check("rst_ifid_en", ifid_en, 1'b1);
        check("rst_idex_flush", idex_flush, 1'b0);
        check("rst_memwb_flush", memwb_flush, 1'b0);
        check("rst_dmem_req", dmem.dmem_req, 1'b0);
        check("rst_mem_err", mem_err, 1'b0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_pc_sel", pc_sel, 2'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        drive();
        run(300);
        acc_pct = 100;
        ack_pct = 0;
        run(40);
        acc_pct = 25;
        ack_pct = 40;
        run(100);
        acc_pct = 100;
        ack_pct = 0;
        run(4);
        @(negedge clk);
        #2;
        check("queue_drained", q.size(), 0);
        clr = 1'b1;
        #1;
        check("async_dmem_req", dmem.dmem_req, 1'b0);
        check("async_stall_cnt", stall_cnt, 0);
        check("async_mem_err", mem_err, 1'b0);
        check("async_exmem_en", exmem_en, 1'b1);
        check("async_memwb_flush", memwb_flush, 1'b0);
        model_reset();
        acc_pct = 25;
        ack_pct = 40;
        @(posedge clk);
        #1;
        clr = 1'b0;
        drive();
        run(200);
        acc_pct = 100;
        ack_pct = 0;
        run(20);
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge clk);
            #2;
        end
        check("final_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
